// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed four-digit seven-segment scanner.
// Font entries are active-high with segment a in bit 0.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_t;

    // Off levels for active-low pins; active-high builds invert them.
    localparam logic [6:0] OFF_SEG = 7'h7F;
    localparam logic [3:0] OFF_SEL = 4'hF;

    // Index 15 sits leftmost, so entry n is HEX_FONT[n].
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dots;
        logic        colon;
    } disp_buf_t;

endpackage

// File: rtl/seven_seg_scanner_hex.sv
// Combinational nibble to seven-segment font lookup.
// The polarity parameter selects whether a lit segment is driven 1 or 0.
module hex_to_seven_seg
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = ACTIVE_LOW ? ~HEX_FONT[i_nibble] : HEX_FONT[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver with double-buffered digits,
// per-slot blanking and a frame_done pulse on every frame commit.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 1000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dot_in,
    input  logic        colon_in,
    output logic [6:0]  segments,
    output logic [3:0]  seg_select,
    output logic        seg_colon,
    output logic        seg_dot,
    output logic        frame_done
);

    localparam int unsigned    CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? OFF_SEG : ~OFF_SEG;
    localparam logic [3:0]     SEL_OFF   = SEL_ACTIVE_LOW ? OFF_SEL : ~OFF_SEL;
    localparam logic           LAMP_OFF  = SEG_ACTIVE_LOW;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_digit;
    slot_state_t   r_state;
    logic          r_force;
    disp_buf_t     r_pend;
    disp_buf_t     r_disp;

    logic          w_wrap;
    logic          w_frame_end;
    logic          w_commit;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_nibble;
    logic [6:0]    w_font;
    logic [3:0]    w_sel_hot;
    disp_buf_t     w_in_buf;

    assign w_wrap      = (r_cnt == CNT_LAST);
    assign w_frame_end = w_wrap && (r_digit == 2'd3);
    // r_force covers the first enabled cycle after a disable, so the frame
    // that follows always shows whatever was loaded while dark.
    assign w_commit    = w_frame_end || r_force;
    assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
    assign w_nibble    = r_disp.digits[{r_digit, 2'b00} +: 4];
    assign w_sel_hot   = 4'b0001 << r_digit;
    assign w_in_buf    = {digits_in, dot_in, colon_in};

    hex_to_seven_seg #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_font (
        .i_nibble (w_nibble),
        .o_seg    (w_font)
    );

    // r_state tracks the phase of r_cnt; the pins show that phase one edge later.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_cnt      <= '0;
            r_digit    <= 2'd0;
            r_state    <= BLANK;
            r_force    <= 1'b0;
            r_pend     <= '0;
            r_disp     <= '0;
            segments   <= SEG_OFF;
            seg_select <= SEL_OFF;
            seg_colon  <= LAMP_OFF;
            seg_dot    <= LAMP_OFF;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_pend <= w_in_buf;
            end
            if (!enable_in) begin
                r_cnt      <= '0;
                r_digit    <= 2'd0;
                r_state    <= BLANK;
                r_force    <= 1'b1;
                segments   <= SEG_OFF;
                seg_select <= SEL_OFF;
                seg_colon  <= LAMP_OFF;
                seg_dot    <= LAMP_OFF;
                frame_done <= 1'b0;
            end else begin
                r_cnt      <= w_cnt_nxt;
                r_state    <= (w_cnt_nxt < CNT_BLANK) ? BLANK : DRIVE;
                frame_done <= w_frame_end;
                if (w_wrap) begin
                    r_digit <= r_digit + 2'd1;
                end
                if (w_commit) begin
                    r_disp  <= load ? w_in_buf : r_pend;
                    r_force <= 1'b0;
                end
                if (r_state == DRIVE) begin
                    segments   <= w_font;
                    seg_select <= SEL_ACTIVE_LOW ? ~w_sel_hot : w_sel_hot;
                    seg_colon  <= r_disp.colon ^ SEG_ACTIVE_LOW;
                    seg_dot    <= r_disp.dots[r_digit] ^ SEG_ACTIVE_LOW;
                end else begin
                    segments   <= SEG_OFF;
                    seg_select <= SEL_OFF;
                    seg_colon  <= LAMP_OFF;
                    seg_dot    <= LAMP_OFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: an active-low and an active-high instance share
// the stimulus; a frame-arithmetic model predicts every cycle's pins.
module tb_seven_seg_scanner;

    localparam int CD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        enable_in;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dot_in;
    logic        colon_in;

    logic [6:0] segments, segments_ah;
    logic [3:0] seg_select, seg_select_ah;
    logic       seg_colon, seg_colon_ah;
    logic       seg_dot, seg_dot_ah;
    logic       frame_done, frame_done_ah;

    int total = 0;
    int bad   = 0;

    logic [6:0] font_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .CLK_DIV(CD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_in(reset_in), .enable_in(enable_in), .load(load),
        .digits_in(digits_in), .dot_in(dot_in), .colon_in(colon_in),
        .segments(segments), .seg_select(seg_select), .seg_colon(seg_colon),
        .seg_dot(seg_dot), .frame_done(frame_done)
    );

    seven_seg_scanner #(
        .CLK_DIV(CD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
    ) dut_ah (
        .clk(clk), .reset_in(reset_in), .enable_in(enable_in), .load(load),
        .digits_in(digits_in), .dot_in(dot_in), .colon_in(colon_in),
        .segments(segments_ah), .seg_select(seg_select_ah), .seg_colon(seg_colon_ah),
        .seg_dot(seg_dot_ah), .frame_done(frame_done_ah)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos counts enabled edges since the scan restarted; phase and digit
    // follow from plain division of that count.
    int          m_pos;
    int          m_phase;
    int          m_dig;
    bit          m_valid = 0;
    bit          m_force;
    logic [15:0] m_disp_d, m_pend_d;
    logic [3:0]  m_disp_dot, m_pend_dot;
    logic        m_disp_col, m_pend_col;
    bit          e_lit, e_fd;
    int          e_dig;
    logic [6:0]  e_font;
    logic        e_dot, e_col;

    always @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            m_pos = 0; m_force = 0; m_valid = 1;
            m_disp_d = '0; m_pend_d = '0; m_disp_dot = '0; m_pend_dot = '0;
            m_disp_col = 1'b0; m_pend_col = 1'b0;
            e_lit = 0; e_fd = 0; e_dig = 0; e_font = '0; e_dot = 1'b0; e_col = 1'b0;
        end else begin
            if (enable_in) begin
                m_phase = m_pos % CD;
                m_dig   = (m_pos / CD) % 4;
                e_lit   = (m_phase >= BC);
                e_dig   = m_dig;
                e_font  = font_tab[m_disp_d[m_dig*4 +: 4]];
                e_dot   = m_disp_dot[m_dig];
                e_col   = m_disp_col;
                e_fd    = (m_phase == CD - 1) && (m_dig == 3);
                if (e_fd || m_force) begin
                    m_disp_d   = load ? digits_in : m_pend_d;
                    m_disp_dot = load ? dot_in    : m_pend_dot;
                    m_disp_col = load ? colon_in  : m_pend_col;
                    m_force    = 0;
                end
                m_pos++;
            end else begin
                e_lit = 0; e_fd = 0; m_pos = 0; m_force = 1;
            end
            if (load) begin
                m_pend_d = digits_in; m_pend_dot = dot_in; m_pend_col = colon_in;
            end
        end
    end

    logic [6:0] x_seg;
    logic [3:0] x_sel;
    logic       x_dot, x_col;

    always @(negedge clk) begin
        if (m_valid) begin
            x_sel = 4'b0001 << e_dig;
            x_seg = e_lit ? e_font : 7'h00;
            x_sel = e_lit ? x_sel  : 4'h0;
            x_dot = e_lit ? e_dot  : 1'b0;
            x_col = e_lit ? e_col  : 1'b0;
            chk("ah_seg", {25'd0, segments_ah}, {25'd0, x_seg});
            chk("ah_sel", {28'd0, seg_select_ah}, {28'd0, x_sel});
            chk("ah_dot", {31'd0, seg_dot_ah}, {31'd0, x_dot});
            chk("ah_col", {31'd0, seg_colon_ah}, {31'd0, x_col});
            chk("ah_fd",  {31'd0, frame_done_ah}, {31'd0, e_fd});
            x_seg = ~x_seg; x_sel = ~x_sel; x_dot = ~x_dot; x_col = ~x_col;
            chk("al_seg", {25'd0, segments}, {25'd0, x_seg});
            chk("al_sel", {28'd0, seg_select}, {28'd0, x_sel});
            chk("al_dot", {31'd0, seg_dot}, {31'd0, x_dot});
            chk("al_col", {31'd0, seg_colon}, {31'd0, x_col});
            chk("al_fd",  {31'd0, frame_done}, {31'd0, e_fd});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic c);
        load = 1'b1; digits_in = d; dot_in = dt; colon_in = c;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL fd_timeout: got=no frame_done want=frame_done within 200 cycles");
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_seg"}, {25'd0, segments}, 32'h7F);
        chk({tag, "_sel"}, {28'd0, seg_select}, 32'hF);
        chk({tag, "_dot"}, {31'd0, seg_dot}, 32'h1);
        chk({tag, "_col"}, {31'd0, seg_colon}, 32'h1);
        chk({tag, "_ahseg"}, {25'd0, segments_ah}, 32'h0);
        chk({tag, "_ahsel"}, {28'd0, seg_select_ah}, 32'h0);
    endtask

    // Call at a negedge where the next edge starts digit 0, phase 0.
    task automatic check_frame(input logic [6:0] f0, input logic [6:0] f1,
                               input logic [6:0] f2, input logic [6:0] f3,
                               input logic [3:0] dots, input logic col);
        logic [6:0] f [4];
        logic [6:0] e_seg;
        logic [3:0] oh, e_sel;
        logic       e_d, e_c;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < CD; c++) begin
                @(negedge clk);
                if (c < BC) begin
                    chk_off("frm_blank");
                end else begin
                    oh = 4'b0001 << k;
                    e_seg = ~f[k]; e_sel = ~oh; e_d = ~dots[k]; e_c = ~col;
                    chk("frm_seg", {25'd0, segments}, {25'd0, e_seg});
                    chk("frm_sel", {28'd0, seg_select}, {28'd0, e_sel});
                    chk("frm_dot", {31'd0, seg_dot}, {31'd0, e_d});
                    chk("frm_col", {31'd0, seg_colon}, {31'd0, e_c});
                    chk("frm_ahseg", {25'd0, segments_ah}, {25'd0, f[k]});
                    chk("frm_ahsel", {28'd0, seg_select_ah}, {28'd0, oh});
                end
            end
        end
        chk("frm_end_fd", {31'd0, frame_done}, 32'h1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_in = 1'b0; enable_in = 1'b0; load = 1'b0;
        digits_in = '0; dot_in = '0; colon_in = 1'b0;

        repeat (3) @(negedge clk);
        chk_off("rst");
        chk("rst_fd", {31'd0, frame_done}, 32'h0);

        // Scan order and dwell
        reset_in = 1'b1; enable_in = 1'b1;
        do_load(16'h3210, 4'b0100, 1'b1);
        wait_fd();
        check_frame(7'h3F, 7'h06, 7'h5B, 7'h4F, 4'b0100, 1'b1);

        // Asynchronous reset while digit 0 is lit
        repeat (4) @(negedge clk);
        #2 reset_in = 1'b0;
        #1 chk_off("async_rst");
        chk("async_rst_fd", {31'd0, frame_done}, 32'h0);
        @(negedge clk);
        reset_in = 1'b1;

        // Font sweep
        for (int v = 0; v < 16; v++) begin
            logic [3:0] nv;
            nv = 4'(v);
            do_load({4{nv}}, 4'b0000, 1'b0);
            wait_fd();
            check_frame(font_tab[v], font_tab[v], font_tab[v], font_tab[v], 4'b0000, 1'b0);
        end

        // Tearing: a mid-frame load must wait for the next commit
        do_load(16'hAAAA, 4'b0000, 1'b0);
        wait_fd();
        repeat (12) @(negedge clk);
        do_load(16'h5555, 4'b0000, 1'b0);
        repeat (15) @(negedge clk);
        chk("tear_d3_seg", {25'd0, segments}, 32'h08);
        chk("tear_d3_sel", {28'd0, seg_select}, 32'h7);
        repeat (4) @(negedge clk);
        chk("tear_fd", {31'd0, frame_done}, 32'h1);
        check_frame(7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'b0000, 1'b0);

        // Load sampled on the commit edge itself
        repeat (CD*4 - 1) @(negedge clk);
        do_load(16'hEEEE, 4'b1111, 1'b0);
        chk("coinc_fd", {31'd0, frame_done}, 32'h1);
        check_frame(7'h79, 7'h79, 7'h79, 7'h79, 4'b1111, 1'b0);

        // Enable gating during digit 2 DRIVE
        repeat (20) @(negedge clk);
        chk("gate_pre_sel", {28'd0, seg_select}, 32'hB);
        enable_in = 1'b0;
        @(negedge clk);
        chk_off("gate_off");
        chk("gate_fd", {31'd0, frame_done}, 32'h0);
        do_load(16'hC0DE, 4'b0001, 1'b1);
        repeat (5) @(negedge clk);
        chk_off("gate_held");
        enable_in = 1'b1;
        check_frame(7'h79, 7'h5E, 7'h3F, 7'h39, 4'b0001, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                digits_in = 16'($urandom);
                dot_in    = 4'($urandom_range(0, 15));
                colon_in  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) == 0) enable_in = ~enable_in;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_in = 1'b0;
                #2 reset_in = 1'b1;
            end
        end
        load = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
